// File: rtl/dht11_responder.sv
// ----------------------------------------------------------------------------
// dht11_responder
//
// Emulates the sensor side of a DHT11 single-wire link. After the host holds
// DATA low for at least START_MIN_US, the block waits, sends the 80/80 us
// response preamble, then 40 bits (hum_i, hum_f, temp_i, temp_f, parity,
// MSB first) using 50 us low + 26/70 us high bit cells. It finishes with a
// 50 us low and a one-cycle frame_done pulse.
//
// Parameters:
//   TICKS_US      clk cycles per microsecond
//   START_MIN_US  minimum accepted host start-low width (us)
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   en            1 = accept new host start pulses
//   data_in       asynchronous sample of the DATA line
//   data_oe       1 = pull DATA low, 0 = release (open-drain)
//   hum_i/hum_f   humidity bytes to send
//   temp_i/temp_f temperature bytes to send
//   busy          high from HOST_WAIT through END_LOW
//   frame_done    one-cycle pulse after a complete frame
// ----------------------------------------------------------------------------
module dht11_responder #(
    parameter int unsigned TICKS_US     = 50,
    parameter int unsigned START_MIN_US = 18000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       data_in,
    output logic       data_oe,
    input  logic [7:0] hum_i,
    input  logic [7:0] hum_f,
    input  logic [7:0] temp_i,
    input  logic [7:0] temp_f,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned START_TICKS = START_MIN_US * TICKS_US;
    localparam int unsigned LONGEST     = (START_TICKS > 80 * TICKS_US) ? START_TICKS : 80 * TICKS_US;
    localparam int unsigned CNT_NEED    = $clog2(LONGEST + 1);
    localparam int unsigned CNT_W       = (CNT_NEED > 20) ? CNT_NEED : 20;

    localparam logic [CNT_W-1:0] C_START = CNT_W'(START_TICKS);
    localparam logic [CNT_W-1:0] C_WAIT  = CNT_W'(30 * TICKS_US - 1);
    localparam logic [CNT_W-1:0] C_RESP  = CNT_W'(80 * TICKS_US - 1);
    localparam logic [CNT_W-1:0] C_BLOW  = CNT_W'(50 * TICKS_US - 1);
    localparam logic [CNT_W-1:0] C_ZERO  = CNT_W'(26 * TICKS_US - 1);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(70 * TICKS_US - 1);
    localparam logic [CNT_W-1:0] C_END   = CNT_W'(50 * TICKS_US - 1);

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        HOST_WAIT,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_sync1;
    logic             r_s;
    logic             r_s_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_bit_idx;
    logic [39:0]      r_frame;
    logic             r_data_oe;
    logic             r_busy;
    logic             r_frame_done;

    logic             w_latch;
    logic             w_bit_adv;
    logic             w_done;
    logic             w_cur_bit;
    logic [7:0]       w_parity;

    // 8-bit context: carry out of the byte sum is discarded
    assign w_parity  = hum_i + hum_f + temp_i + temp_f;
    assign w_cur_bit = r_frame[6'd39 - r_bit_idx];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; durations end when the counter reaches N-1 so each
    // timed state lasts exactly N cycles.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_bit_adv    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && r_s_prev && !r_s) w_next_state = HOST_LOW;
            end
            HOST_LOW: begin
                if (!en) begin
                    w_next_state = IDLE;
                end else if (r_s) begin
                    w_next_state = (r_cnt >= C_START) ? HOST_WAIT : IDLE;
                end
            end
            HOST_WAIT: begin
                if (r_cnt == C_WAIT) begin
                    w_next_state = RESP_LOW;
                    w_latch      = 1'b1;
                end
            end
            RESP_LOW: begin
                if (r_cnt == C_RESP) w_next_state = RESP_HIGH;
            end
            RESP_HIGH: begin
                if (r_cnt == C_RESP) w_next_state = BIT_LOW;
            end
            BIT_LOW: begin
                if (r_cnt == C_BLOW) w_next_state = BIT_HIGH;
            end
            BIT_HIGH: begin
                if (r_cnt == (w_cur_bit ? C_ONE : C_ZERO)) begin
                    if (r_bit_idx == 6'd39) begin
                        w_next_state = END_LOW;
                    end else begin
                        w_next_state = BIT_LOW;
                        w_bit_adv    = 1'b1;
                    end
                end
            end
            END_LOW: begin
                if (r_cnt == C_END) begin
                    w_next_state = IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Synchronizer, duration counter, frame latch and registered outputs.
    // data_oe/busy are decoded from the next state so they change on the same
    // edge as the state and never glitch on the open-drain enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1      <= 1'b1;
            r_s          <= 1'b1;
            r_s_prev     <= 1'b1;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_frame      <= '0;
            r_data_oe    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_sync1  <= data_in;
            r_s      <= r_sync1;
            r_s_prev <= r_s;

            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_latch) begin
                r_frame   <= {hum_i, hum_f, temp_i, temp_f, w_parity};
                r_bit_idx <= '0;
            end else if (w_bit_adv) begin
                r_bit_idx <= r_bit_idx + 6'd1;
            end

            r_data_oe    <= (w_next_state == RESP_LOW) || (w_next_state == BIT_LOW) ||
                            (w_next_state == END_LOW);
            r_busy       <= (w_next_state != IDLE) && (w_next_state != HOST_LOW);
            r_frame_done <= w_done;
        end
    end

    assign data_oe    = r_data_oe;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_dht11_responder.sv
// ----------------------------------------------------------------------------
// Testbench for dht11_responder with TICKS_US=1, START_MIN_US=100.
// The DATA line is modelled as a wired-AND of the host pull-down and the DUT
// open-drain drive, so the DUT sees its own low phases on data_in.
// ----------------------------------------------------------------------------
module tb_dht11_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       host_low = 1'b0;
    logic       data_in;
    logic       data_oe;
    logic [7:0] hum_i = '0, hum_f = '0, temp_i = '0, temp_f = '0;
    logic       busy;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;

    // results of the last receive_frame call
    int          g_lat, g_rlo, g_rhi, g_bad_low, g_end;
    int          g_hi[40];
    logic [39:0] g_bits;
    logic        g_done0, g_done1, g_busy_mid;

    assign data_in = ~(host_low | data_oe);

    always #5 clk = ~clk;

    dht11_responder #(.TICKS_US(1), .START_MIN_US(100)) dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .data_oe(data_oe),
        .hum_i(hum_i), .hum_f(hum_f), .temp_i(temp_i), .temp_f(temp_f),
        .busy(busy), .frame_done(frame_done)
    );

    task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        hum_i = a; hum_f = b; temp_i = c; temp_f = d;
    endtask

    // Host pulls the line low for n cycles; optionally drops en after cycle en_drop_at.
    task automatic host_start(input int n, input int en_drop_at);
        @(posedge clk); #1;
        host_low = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (c == en_drop_at) en = 1'b0;
        end
        host_low = 1'b0;
    endtask

    // Length of the current run of data_oe == v (already in the first cycle).
    task automatic measure(input logic v, output int len);
        len = 1;
        while (len < 150) begin
            @(posedge clk); #1;
            if (data_oe !== v) break;
            len++;
        end
    endtask

    task automatic receive_frame(input int en_drop_bit, input int abort_bit, input bit chg);
        int lo;
        g_lat = 0;
        g_bits = '0;
        g_bad_low = 0;
        g_end = 0;
        g_done0 = 1'b0;
        g_done1 = 1'b1;
        for (int i = 0; i < 40; i++) g_hi[i] = 0;
        while (data_oe !== 1'b1 && g_lat < 200) begin
            @(posedge clk); #1;
            g_lat++;
        end
        g_busy_mid = busy;
        measure(1'b1, g_rlo);
        if (chg) set_bytes(8'h22, 8'h22, 8'h22, 8'h22);
        measure(1'b0, g_rhi);
        for (int i = 0; i < 40; i++) begin
            if (i == abort_bit) return;
            if (i == en_drop_bit) en = 1'b0;
            measure(1'b1, lo);
            if (lo != 50) g_bad_low++;
            measure(1'b0, g_hi[i]);
            g_bits[39-i] = (g_hi[i] > 48);
        end
        measure(1'b1, g_end);
        g_done0 = frame_done;
        @(posedge clk); #1;
        g_done1 = frame_done;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got=%b exp=0", data_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_basic_frame;
        logic [39:0] exp = 40'h37_00_19_00_50;
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        host_start(120, -1);
        receive_frame(-1, -1, 1'b0);
        n_cmp++; if (g_lat < 32 || g_lat > 34) begin n_err++; $display("FAIL basic_latency got=%0d exp=33+/-1", g_lat); end
        n_cmp++; if (g_busy_mid !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b exp=1", g_busy_mid); end
        n_cmp++; if (g_rlo != 80) begin n_err++; $display("FAIL basic_resp_low got=%0d exp=80", g_rlo); end
        n_cmp++; if (g_rhi != 80) begin n_err++; $display("FAIL basic_resp_high got=%0d exp=80", g_rhi); end
        n_cmp++; if (g_bits !== exp) begin n_err++; $display("FAIL basic_bits got=%h exp=%h", g_bits, exp); end
        n_cmp++; if (g_bad_low != 0) begin n_err++; $display("FAIL basic_bit_low got=%0d bad exp=0", g_bad_low); end
        for (int i = 0; i < 40; i++) begin
            int e;
            e = exp[39-i] ? 70 : 26;
            n_cmp++; if (g_hi[i] != e) begin n_err++; $display("FAIL basic_bit_high[%0d] got=%0d exp=%0d", i, g_hi[i], e); end
        end
        n_cmp++; if (g_end != 50) begin n_err++; $display("FAIL basic_end_low got=%0d exp=50", g_end); end
        n_cmp++; if (g_done0 !== 1'b1) begin n_err++; $display("FAIL basic_done_pulse got=%b exp=1", g_done0); end
        n_cmp++; if (g_done1 !== 1'b0) begin n_err++; $display("FAIL basic_done_width got=%b exp=0", g_done1); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_all_ones;
        logic [39:0] exp = 40'hFF_FF_FF_FF_FC;
        set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        host_start(120, -1);
        receive_frame(-1, -1, 1'b0);
        n_cmp++; if (g_bits !== exp) begin n_err++; $display("FAIL ones_bits got=%h exp=%h", g_bits, exp); end
        for (int i = 0; i < 40; i++) begin
            int e;
            e = exp[39-i] ? 70 : 26;
            n_cmp++; if (g_hi[i] != e) begin n_err++; $display("FAIL ones_bit_high[%0d] got=%0d exp=%0d", i, g_hi[i], e); end
        end
        n_cmp++; if (g_done0 !== 1'b1) begin n_err++; $display("FAIL ones_done got=%b exp=1", g_done0); end
    endtask

    task automatic test_short_pulse;
        int act = 0;
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        host_start(50, -1);
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (data_oe !== 1'b0 || busy !== 1'b0) act++;
        end
        n_cmp++; if (act != 0) begin n_err++; $display("FAIL short_ignored got=%0d active cycles exp=0", act); end
        host_start(120, -1);
        receive_frame(-1, -1, 1'b0);
        n_cmp++; if (g_bits !== 40'h37_00_19_00_50) begin n_err++; $display("FAIL short_then_full got=%h exp=3700190050", g_bits); end
        n_cmp++; if (g_done0 !== 1'b1) begin n_err++; $display("FAIL short_then_done got=%b exp=1", g_done0); end
    endtask

    task automatic test_enable;
        int act = 0;
        host_start(120, 60);
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (data_oe !== 1'b0 || busy !== 1'b0) act++;
        end
        n_cmp++; if (act != 0) begin n_err++; $display("FAIL en_low_pulse got=%0d active cycles exp=0", act); end
        en = 1'b1;
        repeat (3) @(posedge clk);
        set_bytes(8'h12, 8'h34, 8'h56, 8'h78);
        host_start(120, -1);
        receive_frame(10, -1, 1'b0);
        n_cmp++; if (g_bits !== 40'h12_34_56_78_14) begin n_err++; $display("FAIL en_drop_bits got=%h exp=1234567814", g_bits); end
        n_cmp++; if (g_done0 !== 1'b1) begin n_err++; $display("FAIL en_drop_done got=%b exp=1", g_done0); end
        en = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        host_start(120, -1);
        receive_frame(-1, 20, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (data_oe !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre_oe got=%b exp=1", data_oe); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (data_oe !== 1'b0) begin n_err++; $display("FAIL rst_mid_oe got=%b exp=0", data_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        set_bytes(8'hA5, 8'h5A, 8'h01, 8'h02);
        host_start(120, -1);
        receive_frame(-1, -1, 1'b0);
        n_cmp++; if (g_bits !== 40'hA5_5A_01_02_02) begin n_err++; $display("FAIL rst_mid_next_bits got=%h exp=A55A010202", g_bits); end
        n_cmp++; if (g_done0 !== 1'b1) begin n_err++; $display("FAIL rst_mid_next_done got=%b exp=1", g_done0); end
    endtask

    task automatic test_back_to_back;
        set_bytes(8'h11, 8'h11, 8'h11, 8'h11);
        host_start(120, -1);
        receive_frame(-1, -1, 1'b1);
        n_cmp++; if (g_bits !== 40'h11_11_11_11_44) begin n_err++; $display("FAIL latch_bits got=%h exp=1111111144", g_bits); end
        host_start(120, -1);
        receive_frame(-1, -1, 1'b0);
        n_cmp++; if (g_bits !== 40'h22_22_22_22_88) begin n_err++; $display("FAIL latch_next_bits got=%h exp=2222222288", g_bits); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_all_ones();
        test_short_pulse();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dht11_responder.md
DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameter TICKS_US, default 50: clk cycles per microsecond.
REQ-002 Parameter START_MIN_US, default 18000: minimum host start-low width in us.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  1 = respond to host start pulses; 0 = ignore new pulses.
REQ-006 data_in  input  1  sampled single-wire DATA line, asynchronous, pulled high when released.
REQ-007 data_oe  output  1  1 = drive DATA low; 0 = release line (open-drain, external tristate).
REQ-008 hum_i, hum_f, temp_i, temp_f  input  8 each  measurement bytes to transmit.
REQ-009 busy  output  1  1 while a response frame is in progress.
REQ-010 frame_done  output  1  single-cycle pulse when a frame completes.

Function
REQ-011 data_in SHALL pass through a 2-flop synchronizer (s) plus a previous-value register (s_prev) before any use.
REQ-012 One free-running duration counter SHALL clear on every state change, saturate at all-ones, and be at least 20 bits wide.
REQ-013 FSM states: IDLE, HOST_LOW, HOST_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-014 IDLE -> HOST_LOW when en=1 and s_prev=1 and s=0; all other IDLE cycles stay in IDLE.
REQ-015 HOST_LOW: count while s=0. When s=1: go to HOST_WAIT if count >= START_MIN_US*TICKS_US, else go to IDLE with no response.
REQ-016 HOST_WAIT: data_oe=0 for 30*TICKS_US cycles, then go to RESP_LOW.
REQ-017 On the HOST_WAIT->RESP_LOW transition, the block SHALL latch the 40-bit frame {hum_i, hum_f, temp_i, temp_f, parity}, where parity = (hum_i+hum_f+temp_i+temp_f) mod 256 (8-bit wrap, carry discarded).
REQ-018 Input byte changes after the latch SHALL NOT affect the frame in flight.
REQ-019 RESP_LOW: data_oe=1 for 80*TICKS_US cycles. RESP_HIGH: data_oe=0 for 80*TICKS_US cycles, then go to BIT_LOW with bit index 0.
REQ-020 Bits SHALL be sent MSB first, hum_i first, parity last (frame bit 39 down to 0).
REQ-021 BIT_LOW: data_oe=1 for 50*TICKS_US cycles.
REQ-022 BIT_HIGH: data_oe=0 for 26*TICKS_US cycles when the bit is 0, or 70*TICKS_US cycles when the bit is 1.
REQ-023 After BIT_HIGH, go to BIT_LOW if bit index < 39 (index increments); otherwise go to END_LOW.
REQ-024 END_LOW: data_oe=1 for 50*TICKS_US cycles, then go to IDLE with frame_done=1 for exactly that one cycle.
REQ-025 busy=1 in HOST_WAIT through END_LOW inclusive; busy=0 in IDLE and HOST_LOW.
REQ-026 During HOST_WAIT through END_LOW, s SHALL be ignored; the block's own drive never retriggers HOST_LOW.
REQ-027 en falling to 0 mid-frame SHALL NOT abort the frame. en falling to 0 in HOST_LOW SHALL return the FSM to IDLE.
REQ-028 Latency from the data_in rising edge ending a valid host pulse to data_oe=1 SHALL be 30*TICKS_US+3 cycles, +/-1.

Reset
REQ-029 With rst=1 at a clock edge: state=IDLE, data_oe=0, busy=0, frame_done=0, counter=0, bit index=0, latched frame=0, synchronizer flops and s_prev=1.
REQ-030 rst asserted mid-frame SHALL release the line (data_oe=0) at that same edge with no partial-bit completion.

Verification (TICKS_US=1, START_MIN_US=100)
REQ-031 Host low 120 cycles, then release; bytes 0x37,0x00,0x19,0x00 -> data_oe low 30(+3+/-1) cycles after release, then 80 cycles asserted, 80 released, 40 bits decode to 0x37,0x00,0x19,0x00,0x50, then 50-cycle END_LOW and a single frame_done pulse.
REQ-032 Bytes 0xFF,0xFF,0xFF,0xFF -> parity byte 0xFC; every bit-1 high phase lasts exactly 70 cycles and every bit-0 high phase exactly 26 cycles.
REQ-033 Host low 50 cycles, then release -> data_oe and busy stay 0, FSM returns to IDLE; a following 120-cycle pulse gets a full response.
REQ-034 en=0 during a 120-cycle host pulse -> no response. en dropped to 0 during bit 10 of a frame -> frame completes with a frame_done pulse.
REQ-035 rst=1 during bit 20 -> data_oe=0, busy=0 at the same edge. A subsequent valid start yields a correct full frame.
REQ-036 Bytes changed from 0x11 to 0x22 during RESP_HIGH -> the transmitted frame carries the 0x11 values and the matching parity.
